// File: rtl/round_sequencer.sv
// round_sequencer: one Tug-of-War match as a series of timed, judged rounds.
// Define FALSE_START_EN to make a press during the hold-off a foul.
module round_sequencer #(
    parameter int WINS_TO_MATCH = 3,
    parameter int MIN_WAIT      = 8,
    parameter int RAND_BITS     = 3,
    parameter int TIMEOUT_TICKS = 64,
    parameter int SHOW_TICKS    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       slowen_i,
    input  logic       rand_i,
    input  logic       pbl_sy_i,
    input  logic       pbr_sy_i,
    output logic       clear_o,
    output logic       armed_o,
    output logic       round_done_o,
    output logic [1:0] round_win_o,
    output logic [3:0] wins_l_o,
    output logic [3:0] wins_r_o,
    output logic       match_over_o,
    output logic       match_win_r_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ARMED = 3'd3;
    localparam logic [2:0] S_JUDGE = 3'd4;
    localparam logic [2:0] S_SHOW  = 3'd5;
    localparam logic [2:0] S_OVER  = 3'd6;
    localparam logic [3:0] WINS    = 4'(WINS_TO_MATCH);

    logic [2:0]           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [RAND_BITS-1:0] acc_q, acc_d;
    logic [RAND_BITS:0]   acc_sh;
    logic [1:0]           win_q, win_d, res;
    logic [3:0]           wl_q, wl_d, wr_q, wr_d;
    logic                 start_q, pbl_q, pbr_q, clear_q;
    logic                 start_e, l_e, r_e, tick_end;

    assign start_e  = start_i & ~start_q;
    assign l_e      = pbl_sy_i & ~pbl_q;
    assign r_e      = pbr_sy_i & ~pbr_q;
    assign tick_end = slowen_i && cnt_q == 8'd1;
    assign res      = (l_e && r_e) ? 2'b00 : {l_e, r_e};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_sh  = {acc_q, rand_i};
        acc_d   = acc_q;
        win_d   = win_q;
        wl_d    = wl_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: if (start_e) begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
            S_CLEAR: begin
                acc_d = acc_sh[RAND_BITS-1:0];
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(RAND_BITS - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'(MIN_WAIT) + 8'(acc_d);
                end
            end
            S_WAIT: begin
`ifdef FALSE_START_EN
                // a foul hands the round to the opponent
                if (l_e || r_e) begin
                    state_d = S_JUDGE;
                    win_d   = {res[0], res[1]};
                end else
`endif
                if (slowen_i) begin
                    cnt_d = cnt_q - 8'd1;
                    if (tick_end) begin
                        state_d = S_ARMED;
                        cnt_d   = 8'(TIMEOUT_TICKS);
                    end
                end
            end
            S_ARMED: if (l_e || r_e) begin
                state_d = S_JUDGE;
                win_d   = res;
            end else if (slowen_i) begin
                cnt_d = cnt_q - 8'd1;
                if (tick_end) begin
                    state_d = S_JUDGE;
                    win_d   = 2'b00;
                end
            end
            S_JUDGE: begin
                state_d = S_SHOW;
                cnt_d   = 8'(SHOW_TICKS);
            end
            S_SHOW: if (slowen_i) begin
                cnt_d = cnt_q - 8'd1;
                if (tick_end) begin
                    state_d = (wl_q == WINS || wr_q == WINS) ? S_OVER : S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_OVER: if (start_e) begin
                state_d = S_CLEAR;
                cnt_d   = '0;
                win_d   = 2'b00;
                wl_d    = '0;
                wr_d    = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // counts move only on the clk that enters JUDGE, saturating at the match target
        if (state_d == S_JUDGE) begin
            wl_d = (win_d[1] && wl_q != WINS) ? wl_q + 4'd1 : wl_q;
            wr_d = (win_d[0] && wr_q != WINS) ? wr_q + 4'd1 : wr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            win_q   <= '0;
            wl_q    <= '0;
            wr_q    <= '0;
            start_q <= 1'b0;
            pbl_q   <= 1'b0;
            pbr_q   <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            win_q   <= win_d;
            wl_q    <= wl_d;
            wr_q    <= wr_d;
            start_q <= start_i;
            pbl_q   <= pbl_sy_i;
            pbr_q   <= pbr_sy_i;
            clear_q <= state_d == S_IDLE || state_d == S_CLEAR;
        end
    end

    assign clear_o       = clear_q;
    assign armed_o       = state_q == S_ARMED;
    assign round_done_o  = state_q == S_JUDGE;
    assign round_win_o   = win_q;
    assign wins_l_o      = wl_q;
    assign wins_r_o      = wr_q;
    assign match_over_o  = state_q == S_OVER;
    assign match_win_r_o = match_over_o && wr_q == WINS;
endmodule
